// File: rtl/aes_inv_key_sched_ctrl.sv
// Sequencer for the word-serial inverse AES-128 key expansion.
// Walks the datapath through steps 0..4*(NR+1)-1. Each group of four steps
// fills one half of a two-entry ping-pong round-key store. Completed round
// keys (round NR down to 0) are offered to the inverse-cipher round datapath
// over a valid/ack handshake. Expansion stalls at a group boundary while the
// target half is still held by the consumer.
module aes_inv_key_sched_ctrl #(
    parameter int NR     = 10,
    parameter int STEP_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              step_en,
    output logic [STEP_W-1:0] step_idx,
    output logic              rk_valid,
    output logic              rk_sel,
    output logic [3:0]        rk_round,
    input  logic              rk_ack,
    output logic              busy,
    output logic              done
);

    localparam int                TOTAL_STEPS = 4 * (NR + 1);
    localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(TOTAL_STEPS - 1);
    localparam logic [3:0]        OUT_ALL     = 4'(NR + 1);
    localparam logic [3:0]        ROUND_TOP   = 4'(NR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [1:0]        buf_full_q, buf_full_d;
    logic              head_q, head_d;
    logic [3:0]        out_cnt_q, out_cnt_d;

    // Decoded view of the current step.
    logic grp_buf;     // target half for the current group (g[0])
    logic grp_first;   // first step of a group: the only place a stall can occur
    logic grp_last;    // last step of a group: completes the round key
    logic stall;
    logic ack_fire;
    logic last_step;
    logic all_out;

    // Step issue and consumer-side outputs, all from registered state only.
    always_comb begin
        grp_buf   = step_cnt_q[2];
        grp_first = (step_cnt_q[1:0] == 2'b00);
        grp_last  = (step_cnt_q[1:0] == 2'b11);
        last_step = (step_cnt_q == LAST_STEP);
        stall     = grp_first && buf_full_q[grp_buf];

        step_en   = (state_q == S_RUN) && !stall;
        step_idx  = step_cnt_q;

        rk_valid  = buf_full_q[head_q];
        rk_sel    = head_q;
        rk_round  = ROUND_TOP - out_cnt_q;
        ack_fire  = rk_valid && rk_ack;

        all_out   = (out_cnt_q == OUT_ALL);
        busy      = (state_q != S_IDLE);
        // Round 0 was acked on the previous edge; pulse once, then go idle.
        done      = (state_q == S_DRAIN) && all_out;
    end

    // Next-state: step counting, buffer fill/free and the control FSM.
    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        buf_full_d = buf_full_q;
        head_d     = head_q;
        out_cnt_d  = out_cnt_q;

        // The consumer frees the offered half regardless of expansion progress.
        if (ack_fire) begin
            buf_full_d[head_q] = 1'b0;
            head_d             = ~head_q;
            out_cnt_d          = out_cnt_q + 4'd1;
        end

        case (state_q)
            S_IDLE: begin
                step_cnt_d = '0;
                buf_full_d = 2'b00;
                head_d     = 1'b0;
                out_cnt_d  = 4'd0;
                if (start && !abort) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (step_en) begin
                    // The half being filled is never the one being acked,
                    // so the set cannot collide with the clear above.
                    if (grp_last) begin
                        buf_full_d[grp_buf] = 1'b1;
                    end
                    if (last_step) begin
                        state_d = S_DRAIN;
                    end else begin
                        step_cnt_d = step_cnt_q + STEP_W'(1);
                    end
                end
            end

            S_DRAIN: begin
                if (all_out) begin
                    state_d    = S_IDLE;
                    step_cnt_d = '0;
                    buf_full_d = 2'b00;
                    head_d     = 1'b0;
                    out_cnt_d  = 4'd0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Cancel drops every pending key and returns to idle without done.
        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            step_cnt_d = '0;
            buf_full_d = 2'b00;
            head_d     = 1'b0;
            out_cnt_d  = 4'd0;
        end
    end

    // State register with asynchronous active-high clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            step_cnt_q <= '0;
            buf_full_q <= 2'b00;
            head_q     <= 1'b0;
            out_cnt_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            buf_full_q <= buf_full_d;
            head_q     <= head_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

endmodule
